// File: rtl/cpu1_oci_pkg.sv
// Shared cpu1 on-chip-instrumentation types: trace-code encoding, packet layout
// and data-trace packer geometry.
package cpu1_oci_pkg;

  localparam int unsigned SLOT_W    = 2;
  localparam int unsigned NUM_SLOTS = 15;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned DCT_W     = SLOT_W * NUM_SLOTS;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);

  typedef enum logic [SLOT_W-1:0] {
    NONE     = 2'b00,
    ADDR     = 2'b01,
    DATA     = 2'b10,
    RESERVED = 2'b11
  } trace_code_e;

  // Packet word handed to the downstream trace FIFO.
  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [DCT_W-1:0] data;
  } dct_pkt_t;

endpackage

// File: rtl/cpu1_oci_dct_packer.sv
// Packs 2-bit data-trace codes into 15-slot packets behind a valid/ready holding
// register. Define CPU1_OCI_DCT_TIMEOUT_EN to auto-flush idle partial packets.
module cpu1_oci_dct_packer
  import cpu1_oci_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trc_en,
  input  logic              item_valid,
  input  logic [SLOT_W-1:0] item_data,
  output logic              in_ready,
  input  logic              flush_req,
  output logic [DCT_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              pkt_valid,
  output logic [DCT_W-1:0]  pkt_data,
  output logic [CNT_W-1:0]  pkt_count,
  input  logic              pkt_ready,
  output logic              overflow,
  input  logic              ovf_clr
);

  if (TIMEOUT == 0) begin : g_timeout_chk
    $error("TIMEOUT must be at least 1");
  end

  logic [DCT_W-1:0] buf_q, buf_d, base_buf;
  logic [CNT_W-1:0] cnt_q, cnt_d, base_cnt;
  dct_pkt_t         pkt_q, pkt_d;
  logic             pv_q, pv_d;
  logic             ovf_q, ovf_d;
  logic             fp_q, fp_d;

  logic drain, slot_free, xfer, acc, drop, tmo_hit;

  always_comb begin
    drain     = pv_q && pkt_ready;
    slot_free = !pv_q || drain;
    xfer      = slot_free && ((cnt_q == FULL_CNT) || (fp_q && (cnt_q != '0)));
    in_ready  = (cnt_q < FULL_CNT) || xfer;
    acc       = item_valid && trc_en && in_ready;
    drop      = item_valid && trc_en && !in_ready;
  end

`ifdef CPU1_OCI_DCT_TIMEOUT_EN
  localparam int unsigned      TMO_W   = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Saturates at TIMEOUT so a stalled partial packet only raises the flush once.
  always_comb begin
    tmo_d   = tmo_q;
    tmo_hit = 1'b0;
    if (acc || xfer) begin
      tmo_d = '0;
    end else if ((cnt_q != '0) && (tmo_q != TMO_MAX)) begin
      tmo_d   = tmo_q + 1'b1;
      tmo_hit = (tmo_d == TMO_MAX);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  always_comb tmo_hit = 1'b0;
`endif

  always_comb begin
    // Transfer empties the accumulator first; a same-cycle code lands in slot 0.
    base_buf = xfer ? '0 : buf_q;
    base_cnt = xfer ? '0 : cnt_q;
    buf_d    = base_buf;
    cnt_d    = base_cnt;
    if (acc) begin
      buf_d = {base_buf[DCT_W-SLOT_W-1:0], item_data};
      cnt_d = base_cnt + 1'b1;
    end

    fp_d = fp_q || flush_req || tmo_hit;
    if (xfer || ((cnt_q == '0) && !acc)) fp_d = 1'b0;

    pv_d  = pv_q;
    pkt_d = pkt_q;
    if (xfer) begin
      pv_d       = 1'b1;
      pkt_d.count = cnt_q;
      pkt_d.data  = buf_q;
    end else if (drain) begin
      pv_d = 1'b0;
    end

    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q <= '0;
      cnt_q <= '0;
      pkt_q <= '0;
      pv_q  <= 1'b0;
      ovf_q <= 1'b0;
      fp_q  <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      pkt_q <= pkt_d;
      pv_q  <= pv_d;
      ovf_q <= ovf_d;
      fp_q  <= fp_d;
    end
  end

  assign dct_buffer = buf_q;
  assign dct_count  = cnt_q;
  assign pkt_valid  = pv_q;
  assign pkt_data   = pkt_q.data;
  assign pkt_count  = pkt_q.count;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_cpu1_oci_dct_packer.sv
// Directed bench for cpu1_oci_dct_packer; timeout expectations follow
// CPU1_OCI_DCT_TIMEOUT_EN with TIMEOUT overridden to 4.
module tb_cpu1_oci_dct_packer;
  import cpu1_oci_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              trc_en;
  logic              item_valid;
  logic [SLOT_W-1:0] item_data;
  logic              in_ready;
  logic              flush_req;
  logic [DCT_W-1:0]  dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              pkt_valid;
  logic [DCT_W-1:0]  pkt_data;
  logic [CNT_W-1:0]  pkt_count;
  logic              pkt_ready;
  logic              overflow;
  logic              ovf_clr;

  int nvec = 0;
  int nmis = 0;

  cpu1_oci_dct_packer #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .trc_en     (trc_en),
    .item_valid (item_valid),
    .item_data  (item_data),
    .in_ready   (in_ready),
    .flush_req  (flush_req),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .pkt_valid  (pkt_valid),
    .pkt_data   (pkt_data),
    .pkt_count  (pkt_count),
    .pkt_ready  (pkt_ready),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; trc_en = 1'b1; item_valid = 1'b0; item_data = '0;
    flush_req = 1'b0; pkt_ready = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_count", 32'(dct_count), 32'd0);
    chk("rst_pkt_valid", 32'(pkt_valid), 32'd0);

    // 1: reset mid-packet is asynchronous
    item_valid = 1'b1; item_data = 2'b11;
    for (int i = 0; i < 5; i++) tick();
    item_valid = 1'b0;
    chk("t1_count5", 32'(dct_count), 32'd5);
    chk("t1_buf5", 32'(dct_buffer), 32'h3FF);
    #2 reset = 1'b1;
    #1;
    chk("t1_async_count", 32'(dct_count), 32'd0);
    chk("t1_async_buf", 32'(dct_buffer), 32'd0);
    chk("t1_async_pv", 32'(pkt_valid), 32'd0);
    chk("t1_async_ovf", 32'(overflow), 32'd0);
    tick();
    reset = 1'b0;

    // 2: full packet of ADDR codes
    pkt_ready = 1'b1;
    item_valid = 1'b1; item_data = ADDR;
    for (int i = 0; i < 15; i++) tick();
    item_valid = 1'b0;
    chk("t2_count15", 32'(dct_count), 32'd15);
    chk("t2_buf15", 32'(dct_buffer), 32'h15555555);
    chk("t2_pv_before", 32'(pkt_valid), 32'd0);
    chk("t2_in_ready_full_xfer", 32'(in_ready), 32'd1);
    tick();
    chk("t2_pv", 32'(pkt_valid), 32'd1);
    chk("t2_data", 32'(pkt_data), 32'h15555555);
    chk("t2_pcount", 32'(pkt_count), 32'd15);
    chk("t2_acc_clear_cnt", 32'(dct_count), 32'd0);
    chk("t2_acc_clear_buf", 32'(dct_buffer), 32'd0);
    tick();
    chk("t2_drained", 32'(pkt_valid), 32'd0);
    chk("t2_data_hold", 32'(pkt_data), 32'h15555555);

    // 3: back-to-back under stall, 31 codes
    pkt_ready = 1'b0;
    item_valid = 1'b1;
    for (int i = 0; i < 31; i++) begin
      item_data = (i < 15) ? 2'b10 : ((i < 30) ? 2'b11 : 2'b01);
      tick();
    end
    chk("t3_pv", 32'(pkt_valid), 32'd1);
    chk("t3_pkt1_data", 32'(pkt_data), 32'h2AAAAAAA);
    chk("t3_pkt1_count", 32'(pkt_count), 32'd15);
    chk("t3_count2", 32'(dct_count), 32'd15);
    chk("t3_buf2", 32'(dct_buffer), 32'h3FFFFFFF);
    chk("t3_in_ready0", 32'(in_ready), 32'd0);
    chk("t3_ovf", 32'(overflow), 32'd1);
    item_data = 2'b01; ovf_clr = 1'b1;
    tick();
    chk("t3_ovf_set_wins", 32'(overflow), 32'd1);
    chk("t3_stall_data", 32'(pkt_data), 32'h2AAAAAAA);
    item_valid = 1'b0;
    tick();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", 32'(overflow), 32'd0);
    pkt_ready = 1'b1;
    #1;
    chk("t3_in_ready_drain", 32'(in_ready), 32'd1);
    tick();
    chk("t3_pkt2_pv", 32'(pkt_valid), 32'd1);
    chk("t3_pkt2_data", 32'(pkt_data), 32'h3FFFFFFF);
    chk("t3_pkt2_count", 32'(pkt_count), 32'd15);
    chk("t3_acc_empty", 32'(dct_count), 32'd0);
    tick();
    chk("t3_drained", 32'(pkt_valid), 32'd0);

    // 4: flush partial packet, then flush on empty
    item_valid = 1'b1;
    item_data = 2'b10; tick();
    item_data = 2'b11; tick();
    item_data = 2'b01; tick();
    item_valid = 1'b0;
    chk("t4_count3", 32'(dct_count), 32'd3);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("t4_pv_pending", 32'(pkt_valid), 32'd0);
    tick();
    chk("t4_pv", 32'(pkt_valid), 32'd1);
    chk("t4_data", 32'(pkt_data), 32'h2D);
    chk("t4_pcount", 32'(pkt_count), 32'd3);
    chk("t4_acc_empty", 32'(dct_count), 32'd0);
    tick();
    chk("t4_drained", 32'(pkt_valid), 32'd0);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("t4_no_empty_pkt", 32'(pkt_valid), 32'd0);
    chk("t4_pcount_hold", 32'(pkt_count), 32'd3);

    // 5: transfer and accept in the same cycle
    item_valid = 1'b1; item_data = 2'b01;
    for (int i = 0; i < 15; i++) tick();
    item_data = 2'b10;
    tick();
    item_valid = 1'b0;
    chk("t5_pv", 32'(pkt_valid), 32'd1);
    chk("t5_data", 32'(pkt_data), 32'h15555555);
    chk("t5_pcount", 32'(pkt_count), 32'd15);
    chk("t5_count1", 32'(dct_count), 32'd1);
    chk("t5_buf1", 32'(dct_buffer), 32'h2);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("t5_drain", 32'(pkt_valid), 32'd0);
    tick();
    chk("t5_flush_pv", 32'(pkt_valid), 32'd1);
    chk("t5_flush_data", 32'(pkt_data), 32'h2);
    chk("t5_flush_count", 32'(pkt_count), 32'd1);
    tick();

    // trace disabled: codes ignored, no overflow
    trc_en = 1'b0; item_valid = 1'b1; item_data = 2'b11;
    tick();
    chk("te_count", 32'(dct_count), 32'd0);
    chk("te_ovf", 32'(overflow), 32'd0);
    trc_en = 1'b1;

    // 6: idle timeout
    item_data = 2'b11; tick();
    item_data = 2'b01; tick();
    item_valid = 1'b0;
    chk("t6_count2", 32'(dct_count), 32'd2);
`ifdef CPU1_OCI_DCT_TIMEOUT_EN
    for (int i = 0; i < 4; i++) tick();
    chk("t6_pv_pending", 32'(pkt_valid), 32'd0);
    tick();
    chk("t6_pv", 32'(pkt_valid), 32'd1);
    chk("t6_pcount", 32'(pkt_count), 32'd2);
    chk("t6_data", 32'(pkt_data), 32'hD);
`else
    for (int i = 0; i < 70; i++) tick();
    chk("t6_no_pkt", 32'(pkt_valid), 32'd0);
    chk("t6_count_hold", 32'(dct_count), 32'd2);
    chk("t6_buf_hold", 32'(dct_buffer), 32'hD);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/cpu1_oci_dct_packer.md
Name: cpu1_oci_dct_packer

Overview:
- Data-trace compression packer for the cpu1 on-chip instrumentation.
- Accepts a stream of 2-bit compressed data-trace codes and shifts them into a 15-slot, 30-bit accumulator.
- Publishes the live accumulator as dct_buffer/dct_count to the trace test bench.
- Hands completed packets (full or flushed) to the downstream trace FIFO through a valid/ready holding register.

Parameters:
- SLOT_W, 2, bits per trace code.
- NUM_SLOTS, 15, slots per packet; accumulator width = SLOT_W*NUM_SLOTS = 30.
- CNT_W, 4, width of slot counters.
- TIMEOUT, 64, idle cycles before auto-flush (used only with the optional feature).

Ports:
- clk  in  1  trace clock
- reset  in  1  asynchronous active-high reset
- trc_en  in  1  trace enable; when 0, items are ignored
- item_valid  in  1  trace code present
- item_data  in  2  trace code
- in_ready  out  1  code accepted this cycle when high with item_valid and trc_en
- flush_req  in  1  single-cycle request to emit a partial packet
- dct_buffer  out  30  live accumulator; newest code in [1:0]
- dct_count  out  4  live slot count, 0..15
- pkt_valid  out  1  holding register occupied
- pkt_data  out  30  packet payload
- pkt_count  out  4  valid slots in the packet, 1..15
- pkt_ready  in  1  downstream consumes when pkt_valid && pkt_ready
- overflow  out  1  sticky dropped-code flag
- ovf_clr  in  1  clears overflow

Behaviour:
- Reset (async, active-high) clears these outputs to 0: dct_buffer, dct_count, pkt_valid, pkt_data, pkt_count, overflow. Reset also clears flush_pending and the timeout counter. Reset mid-packet discards all held and accumulated data.
- Accept: acc = item_valid && trc_en && in_ready.
  - On accept: dct_buffer <= {dct_buffer[27:0], item_data}; dct_count += 1.
  - Latency: 1 cycle to dct_buffer/dct_count.
- drain = pkt_valid && pkt_ready.
- slot_free = !pkt_valid || drain.
- Transfer condition: xfer = slot_free && ((dct_count==15) || (flush_pending && dct_count!=0)).
- On xfer:
  - pkt_data <= dct_buffer, pkt_count <= dct_count, pkt_valid <= 1.
  - Accumulator is cleared.
  - A code accepted in the same cycle lands in the fresh accumulator: dct_buffer = {28'b0, item_data}, dct_count = 1.
- Drain without xfer: pkt_valid <= 0. Payload registers hold their last value.
- in_ready = (dct_count < 15) || xfer. The count never exceeds 15.
- Overflow: item_valid && trc_en && !in_ready sets overflow; the code is dropped.
  - ovf_clr clears overflow.
  - If set and clear coincide, set wins.
- Flush handling:
  - flush_req sets flush_pending.
  - flush_pending clears on xfer.
  - flush_pending also clears immediately if dct_count==0 with no accept that cycle; no empty packets are ever emitted.
  - A flush arriving while pkt_valid is stalled stays pending until the slot frees.
- trc_en=0:
  - No accepts and no overflow.
  - The accumulator holds its contents.
  - Pending flushes and transfers still proceed.
- Stall rule: pkt_data/pkt_count must stay stable while pkt_valid && !pkt_ready.

Optional Feature:
- Macro: CPU1_OCI_DCT_TIMEOUT_EN.
- When defined:
  - A counter (width clog2(TIMEOUT+1)) increments each cycle dct_count!=0 and no accept occurs.
  - The counter resets on accept or xfer.
  - On reaching TIMEOUT it sets flush_pending, giving an auto-flush of partial packets.
- When undefined:
  - No counter logic exists.
  - Partial packets leave only via flush_req.

Decomposition:
- Shared package cpu1_oci_pkg holds:
  - SLOT_W, NUM_SLOTS, CNT_W, and DCT_W = 30 constants.
  - A 2-bit trace-code enum: NONE, ADDR, DATA, RESERVED.
  - A packed dct_pkt_t struct {count, data}, reused by the downstream trace FIFO.
- No sub-module; the timeout counter stays inline under the macro.

Test Plan:
1. Reset mid-packet: accept 5 codes, assert reset -> dct_count=0, dct_buffer=0, pkt_valid=0, overflow=0 immediately (async).
2. Full packet: 15 codes of 2'b01, pkt_ready=1 -> pkt_valid one cycle after the 15th accept; pkt_data=30'h15555555, pkt_count=15; accumulator returns to 0.
3. Back-to-back under stall: pkt_ready=0, 31 codes. Expected result:
   - First packet held stable.
   - Second accumulator reaches 15 with in_ready=0.
   - The 31st code sets overflow.
   - Raise pkt_ready: packet 2 transfers on the drain cycle and in_ready returns to 1.
4. Flush partial: 3 codes (2,3,1), then flush_req -> pkt_count=3, pkt_data=30'h0000002D. A flush_req with dct_count=0 emits no packet.
5. Simultaneous xfer + accept: 15th code, then a 16th code in the xfer cycle -> packet holds the first 15; dct_count=1, dct_buffer holds the 16th code.
6. With CPU1_OCI_DCT_TIMEOUT_EN and TIMEOUT=4: 2 codes then idle -> flush_pending after 4 idle cycles; packet has pkt_count=2. With the macro undefined, no packet is emitted.
